// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    FETCH    = 4'd1,
    IR_WAIT  = 4'd2,
    DECODE   = 4'd3,
    PC_INC   = 4'd4,
    R_EXEC   = 4'd5,
    I_EXEC   = 4'd6,
    LUI_EXEC = 4'd7,
    ADDR     = 4'd8,
    LD_MEM   = 4'd9,
    LD_MDR   = 4'd10,
    WB       = 4'd11,
    SD_MEM   = 4'd12,
    BRANCH   = 4'd13,
    ERROR    = 4'd14
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LUI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } iclass_e;

  typedef struct packed {
    iclass_e cls;
    logic    illegal;
    logic    f7_ok;
    logic    f7_sub;
    logic    beq;
    logic    bne;
  } dec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/ctrl_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface ctrl_if;
  logic [6:0]  IR6_0;
  logic [4:0]  IR11_7;
  logic [31:0] IR31_0;
  logic        IGUAL;
  logic        PC_WRITE;
  logic        IR_WIRE;
  logic        LOAD_A;
  logic        LOAD_B;
  logic        LOAD_ALU_OUT;
  logic        LOAD_MDR;
  logic        BANCO_WIRE;
  logic        DMEM_RW;
  logic        MEM32_WIRE;
  logic        MUX_MR_WIRE;
  logic        PC_SRC;
  logic [1:0]  ALU_SRCA;
  logic [1:0]  ALU_SRCB;
  logic [2:0]  ALU_SELECTOR;
  logic [15:0] SAIDA_ESTADO;

  modport master (
    input  IR6_0, IR11_7, IR31_0, IGUAL,
    output PC_WRITE, IR_WIRE, LOAD_A, LOAD_B, LOAD_ALU_OUT, LOAD_MDR,
           BANCO_WIRE, DMEM_RW, MEM32_WIRE, MUX_MR_WIRE, PC_SRC,
           ALU_SRCA, ALU_SRCB, ALU_SELECTOR, SAIDA_ESTADO
  );

  modport slave (
    output IR6_0, IR11_7, IR31_0, IGUAL,
    input  PC_WRITE, IR_WIRE, LOAD_A, LOAD_B, LOAD_ALU_OUT, LOAD_MDR,
           BANCO_WIRE, DMEM_RW, MEM32_WIRE, MUX_MR_WIRE, PC_SRC,
           ALU_SRCA, ALU_SRCB, ALU_SELECTOR, SAIDA_ESTADO
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7 -> class and flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  // Classify the opcode; load/store accept only the doubleword width.
  always_comb begin
    dec        = '0;
    dec.cls    = CLS_ILLEGAL;
    dec.f7_ok  = (funct7 == F7_ADD) || (funct7 == F7_SUB);
    dec.f7_sub = (funct7 == F7_SUB);
    dec.beq    = (funct3 == F3_BEQ);
    dec.bne    = (funct3 == F3_BNE);
    case (opcode)
      OP_R:      dec.cls = CLS_R;
      OP_I:      dec.cls = CLS_I;
      OP_LUI:    dec.cls = CLS_LUI;
      OP_LOAD:   if (funct3 == F3_DWORD) dec.cls = CLS_LOAD;
      OP_STORE:  if (funct3 == F3_DWORD) dec.cls = CLS_STORE;
      OP_BRANCH: dec.cls = CLS_BRANCH;
      default:   dec.cls = CLS_ILLEGAL;
    endcase
    dec.illegal = (dec.cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle control unit: fetch/decode/execute sequencing with Moore outputs.
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic    CLK,
  input  logic    RESET,
  ctrl_if.master  bus
);

  state_e state;
  state_e next_state;
  dec_t   dec;

  ctrl_decode u_decode (
    .opcode (bus.IR6_0),
    .funct3 (bus.IR31_0[14:12]),
    .funct7 (bus.IR31_0[31:25]),
    .dec    (dec)
  );

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) state <= RESET_ST;
    else       state <= next_state;
  end

  // Next-state sequencing and opcode dispatch.
  always_comb begin
    next_state = ERROR;
    case (state)
      RESET_ST: next_state = FETCH;
      FETCH:    next_state = IR_WAIT;
      IR_WAIT:  next_state = DECODE;
      DECODE:   next_state = PC_INC;
      PC_INC: begin
        case (dec.cls)
          CLS_R:                next_state = R_EXEC;
          CLS_I:                next_state = I_EXEC;
          CLS_LUI:              next_state = LUI_EXEC;
          CLS_LOAD, CLS_STORE:  next_state = ADDR;
          CLS_BRANCH:           next_state = BRANCH;
          default:              next_state = ERROR;
        endcase
      end
      R_EXEC:   next_state = dec.f7_ok ? WB : ERROR;
      I_EXEC:   next_state = WB;
      LUI_EXEC: next_state = WB;
      ADDR: begin
        if (dec.cls == CLS_LOAD)       next_state = LD_MEM;
        else if (dec.cls == CLS_STORE) next_state = SD_MEM;
        else                           next_state = ERROR;
      end
      LD_MEM:   next_state = LD_MDR;
      LD_MDR:   next_state = WB;
      WB:       next_state = FETCH;
      SD_MEM:   next_state = FETCH;
      BRANCH:   next_state = FETCH;
      ERROR:    next_state = ERROR;
      default:  next_state = ERROR;
    endcase
  end

  // Output decode; only PC_WRITE in BRANCH looks at IGUAL.
  always_comb begin
    bus.PC_WRITE     = 1'b0;
    bus.IR_WIRE      = 1'b0;
    bus.LOAD_A       = 1'b0;
    bus.LOAD_B       = 1'b0;
    bus.LOAD_ALU_OUT = 1'b0;
    bus.LOAD_MDR     = 1'b0;
    bus.BANCO_WIRE   = 1'b0;
    bus.DMEM_RW      = 1'b0;
    bus.MEM32_WIRE   = 1'b0;
    bus.MUX_MR_WIRE  = 1'b0;
    bus.PC_SRC       = 1'b0;
    bus.ALU_SRCA     = '0;
    bus.ALU_SRCB     = '0;
    bus.ALU_SELECTOR = '0;
    bus.SAIDA_ESTADO = {12'h000, state};
    case (state)
      IR_WAIT: bus.IR_WIRE = 1'b1;
      DECODE: begin
        bus.LOAD_A       = 1'b1;
        bus.LOAD_B       = 1'b1;
        bus.ALU_SRCA     = SRCA_PC;
        bus.ALU_SRCB     = SRCB_IMM_SH;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.LOAD_ALU_OUT = 1'b1;
      end
      PC_INC: begin
        bus.ALU_SRCA     = SRCA_PC;
        bus.ALU_SRCB     = SRCB_FOUR;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.PC_SRC       = 1'b0;
        bus.PC_WRITE     = 1'b1;
      end
      R_EXEC: begin
        bus.ALU_SRCA     = SRCA_A;
        bus.ALU_SRCB     = SRCB_B;
        bus.ALU_SELECTOR = dec.f7_sub ? ALU_SUB : ALU_ADD;
        bus.LOAD_ALU_OUT = 1'b1;
      end
      I_EXEC, ADDR: begin
        bus.ALU_SRCA     = SRCA_A;
        bus.ALU_SRCB     = SRCB_IMM;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.LOAD_ALU_OUT = 1'b1;
      end
      LUI_EXEC: begin
        bus.ALU_SRCA     = SRCA_ZERO;
        bus.ALU_SRCB     = SRCB_IMM;
        bus.ALU_SELECTOR = ALU_ADD;
        bus.LOAD_ALU_OUT = 1'b1;
      end
      LD_MEM:   bus.DMEM_RW  = 1'b0;
      LD_MDR:   bus.LOAD_MDR = 1'b1;
      WB: begin
        bus.BANCO_WIRE  = (bus.IR11_7 != '0);
        bus.MUX_MR_WIRE = (dec.cls == CLS_LOAD);
      end
      SD_MEM:   bus.DMEM_RW = 1'b1;
      BRANCH: begin
        bus.ALU_SRCA     = SRCA_A;
        bus.ALU_SRCB     = SRCB_B;
        bus.ALU_SELECTOR = ALU_CMP;
        bus.PC_SRC       = 1'b1;
        bus.PC_WRITE     = (dec.beq & bus.IGUAL) | (dec.bne & ~bus.IGUAL);
      end
      default: ;
    endcase
  end

endmodule
